pipe_mem: RTL and testbench

PIPE_MEM -- requirements
Module: pipe_mem

---
 rtl/pipe_mem_pkg.sv | 89 ++++++++
 rtl/pipe_mem_dly.sv | 51 +++++
 rtl/pipe_mem.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_mem.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// pipe_mem_pkg -- shared types, limits and lane helpers for pipe_mem.
//   width_e  : data-port access width encoding (2'b11 is illegal)
//   state_e  : data-port control states
//   MAX_LATENCY : largest supported read-response delay
//   access_err / load_extract / store_merge : big-endian lane helpers
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } width_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  localparam int MAX_LATENCY = 4;

  // Misaligned half/word and the unused width code are all errors.
  function automatic logic access_err(input logic [1:0] width, input logic [1:0] off);
    logic v_err;
    case (width)
      BYTE:    v_err = 1'b0;
      HALF:    v_err = off[0];
      WORD:    v_err = (off != 2'b00);
      default: v_err = 1'b1;
    endcase
    return v_err;
  endfunction

  // Big-endian lane select: offset 0 is the most significant byte/half.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  width,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    logic [31:0] v_res;
    case (off)
      2'b00:   v_b = word[31:24];
      2'b01:   v_b = word[23:16];
      2'b10:   v_b = word[15:8];
      2'b11:   v_b = word[7:0];
      default: v_b = 8'h00;
    endcase
    if (off[1]) begin
      v_h = word[15:0];
    end else begin
      v_h = word[31:16];
    end
    case (width)
      BYTE:    v_res = {{24{sgn & v_b[7]}}, v_b};
      HALF:    v_res = {{16{sgn & v_h[15]}}, v_h};
      WORD:    v_res = word;
      default: v_res = 32'h0000_0000;
    endcase
    return v_res;
  endfunction

  // Replace one byte/half lane of a word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  width,
                                              input logic [1:0]  off);
    logic [31:0] v_res;
    v_res = word;
    if (width == BYTE) begin
      case (off)
        2'b00:   v_res[31:24] = wdata[7:0];
        2'b01:   v_res[23:16] = wdata[7:0];
        2'b10:   v_res[15:8]  = wdata[7:0];
        2'b11:   v_res[7:0]   = wdata[7:0];
        default: v_res = word;
      endcase
    end else if (width == HALF) begin
      if (off[1]) begin
        v_res[15:0] = wdata;
      end else begin
        v_res[31:16] = wdata;
      end
    end else begin
      v_res = word;
    end
    return v_res;
  endfunction

endpackage

// File: rtl/pipe_mem_dly.sv
// pipe_mem_dly -- valid+data delay line of LATENCY register stages with a
// synchronous clear. Output appears LATENCY edges after the input is sampled.
//   clk     in  clock
//   i_clr   in  synchronous clear of all stages
//   i_valid in  stage-0 valid
//   i_data  in  stage-0 data (W bits)
//   o_valid out last-stage valid
//   o_data  out last-stage data
module pipe_mem_dly #(
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [LATENCY-1:0]        r_vld;
  logic [LATENCY-1:0][W-1:0] r_dat;

  if (LATENCY > 1) begin : g_multi
    // Shift register: stage 0 takes the input, each later stage its predecessor.
    always_ff @(posedge clk) begin
      if (i_clr) begin
        r_vld <= '0;
        r_dat <= '0;
      end else begin
        r_vld <= {r_vld[LATENCY-2:0], i_valid};
        r_dat <= {r_dat[LATENCY-2:0], i_data};
      end
    end
  end else begin : g_single
    // Single stage register.
    always_ff @(posedge clk) begin
      if (i_clr) begin
        r_vld <= '0;
        r_dat <= '0;
      end else begin
        r_vld <= i_valid;
        r_dat <= i_data;
      end
    end
  end

  assign o_valid = r_vld[LATENCY-1];
  assign o_data  = r_dat[LATENCY-1];

endmodule

// File: rtl/pipe_mem.sv
// pipe_mem -- word memory with a load/store data port and a fetch port.
// Big-endian byte lanes; sub-word stores are read-modify-write via MERGE.
// Optional macro PIPE_MEM_STATS_EN adds saturating request counters.
//   clk, rst           clock, synchronous active-high reset
//   d_valid/d_ready    data request handshake
//   d_addr, d_we, d_width, d_signed, d_wdata   request fields
//   d_rvalid/d_rdata/d_err   load / error-store response
//   i_valid, i_addr    fetch request (always accepted)
//   i_rvalid/i_rdata   fetch response
//   stat_loads/stat_stores/stat_errs  (PIPE_MEM_STATS_EN only)
module pipe_mem
  import pipe_mem_pkg::*;
#(
  parameter int    ABits         = 13,
  parameter int    LATENCY       = 1,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [1:0]  d_width,
  input  logic        d_signed,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata
`ifdef PIPE_MEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam int DEPTH = 2 ** (ABits - 2);
  // Out-of-range LATENCY is clamped into 1..MAX_LATENCY.
  localparam int LAT   = (LATENCY > MAX_LATENCY) ? MAX_LATENCY : ((LATENCY < 1) ? 1 : LATENCY);

  logic [31:0] r_mem [DEPTH];

  state_e r_state;
  state_e w_state_nxt;

  logic [ABits-3:0] w_d_idx;
  logic [ABits-3:0] w_i_idx;
  logic [31:0]      w_d_word;
  logic [31:0]      w_i_word;
  logic             w_acc;
  logic             w_err;
  logic             w_st_word;
  logic             w_st_sub;
  logic             w_rsp_valid;
  logic [31:0]      w_rsp_data;

  logic [ABits-3:0] r_m_idx;
  logic [31:0]      r_m_word;
  logic [15:0]      r_m_wdata;
  logic [1:0]       r_m_width;
  logic [1:0]       r_m_off;

  logic             w_mem_we;
  logic [ABits-3:0] w_mem_idx;
  logic [31:0]      w_mem_wdata;

  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{d_addr[31:ABits], i_addr[31:ABits], i_addr[1:0], d_wdata[31:16]};

  assign w_d_idx  = d_addr[ABits-1:2];
  assign w_i_idx  = i_addr[ABits-1:2];
  assign w_d_word = r_mem[w_d_idx];
  assign w_i_word = r_mem[w_i_idx];

  assign d_ready     = (r_state == IDLE) && !rst;
  assign w_acc       = d_valid && d_ready;
  assign w_err       = access_err(d_width, d_addr[1:0]);
  assign w_st_word   = w_acc && d_we && !w_err && (d_width == WORD);
  assign w_st_sub    = w_acc && d_we && !w_err && (d_width != WORD);
  // Loads always respond; stores respond only when rejected as errors.
  assign w_rsp_valid = w_acc && (!d_we || w_err);

  // Load data for the response pipe; zero for errors, stores and idle cycles.
  always_comb begin
    w_rsp_data = 32'h0000_0000;
    if (w_rsp_valid && !w_err) begin
      w_rsp_data = load_extract(w_d_word, d_width, d_addr[1:0], d_signed);
    end else begin
      w_rsp_data = 32'h0000_0000;
    end
  end

  // Next-state logic for the sub-word store sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_st_sub) begin
          w_state_nxt = MERGE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MERGE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the old word and the store lane when a sub-word store is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_idx   <= '0;
      r_m_word  <= 32'h0000_0000;
      r_m_wdata <= 16'h0000;
      r_m_width <= 2'b00;
      r_m_off   <= 2'b00;
    end else if (w_st_sub) begin
      r_m_idx   <= w_d_idx;
      r_m_word  <= w_d_word;
      r_m_wdata <= d_wdata[15:0];
      r_m_width <= d_width;
      r_m_off   <= d_addr[1:0];
    end
  end

  // Single write port: MERGE write-back, else an accepted word store.
  // Reset suppresses a pending MERGE write.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_d_idx;
    w_mem_wdata = d_wdata;
    if (rst) begin
      w_mem_we = 1'b0;
    end else if (r_state == MERGE) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_m_idx;
      w_mem_wdata = store_merge(r_m_word, r_m_wdata, r_m_width, r_m_off);
    end else if (w_st_word) begin
      w_mem_we = 1'b1;
    end else begin
      w_mem_we = 1'b0;
    end
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  pipe_mem_dly #(.LATENCY(LAT), .W(33)) u_d_dly (
    .clk     (clk),
    .i_clr   (rst),
    .i_valid (w_rsp_valid),
    .i_data  ({w_err, w_rsp_data}),
    .o_valid (d_rvalid),
    .o_data  ({d_err, d_rdata})
  );

  pipe_mem_dly #(.LATENCY(LAT), .W(32)) u_i_dly (
    .clk     (clk),
    .i_clr   (rst),
    .i_valid (i_valid),
    .i_data  (i_valid ? w_i_word : 32'h0000_0000),
    .o_valid (i_rvalid),
    .o_data  (i_rdata)
  );

`ifdef PIPE_MEM_STATS_EN
  logic [31:0] r_loads;
  logic [31:0] r_stores;
  logic [31:0] r_errs;

  // Saturating request counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loads  <= 32'h0000_0000;
      r_stores <= 32'h0000_0000;
      r_errs   <= 32'h0000_0000;
    end else begin
      if (w_acc && !d_we && (r_loads != 32'hFFFF_FFFF)) begin
        r_loads <= r_loads + 32'd1;
      end
      if (w_acc && d_we && (r_stores != 32'hFFFF_FFFF)) begin
        r_stores <= r_stores + 32'd1;
      end
      if (w_acc && w_err && (r_errs != 32'hFFFF_FFFF)) begin
        r_errs <= r_errs + 32'd1;
      end
    end
  end

  assign stat_loads  = r_loads;
  assign stat_stores = r_stores;
  assign stat_errs   = r_errs;
`endif

endmodule

// File: tb/tb_pipe_mem.sv
// tb_pipe_mem -- scoreboard bench for pipe_mem (LATENCY=2). Expected load
// and fetch responses are queued at acceptance from a reference memory model
// and checked (data, error flag, arrival time) when the DUT responds.
module tb_pipe_mem;

  localparam int LAT = 2;
  localparam int PER = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid, d_ready, d_we, d_signed, d_rvalid, d_err;
  logic [1:0]  d_width;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        i_valid, i_rvalid;
  logic [31:0] i_addr, i_rdata;
`ifdef PIPE_MEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  pipe_mem #(.ABits(13), .LATENCY(LAT), .MEM_INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_we(d_we),
    .d_width(d_width), .d_signed(d_signed), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .i_valid(i_valid), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata)
`ifdef PIPE_MEM_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  always #(PER/2) clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    longint      t;
  } exp_t;

  exp_t        dq[$];
  exp_t        iq[$];
  logic [31:0] mdl [0:2047];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] wd,
                                           input logic [1:0] off, input logic sg);
    logic [31:0] v;
    int o;
    o = int'(off);
    if (wd == 2'b00) begin
      v = (w >> (8 * (3 - o))) & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (wd == 2'b01) begin
      v = (w >> (16 * (1 - o / 2))) & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [31:0] wdata,
                                            input logic [1:0] wd, input logic [1:0] off);
    int sh;
    logic [31:0] m;
    if (wd == 2'b00) begin
      sh = 8 * (3 - int'(off));
      m  = 32'h0000_00FF << sh;
      return (w & ~m) | ((wdata & 32'h0000_00FF) << sh);
    end else if (wd == 2'b01) begin
      sh = 16 * (1 - int'(off) / 2);
      m  = 32'h0000_FFFF << sh;
      return (w & ~m) | ((wdata & 32'h0000_FFFF) << sh);
    end else begin
      return wdata;
    end
  endfunction

  // One request cycle: optional data request (waits for d_ready) plus optional fetch.
  task automatic req(input logic dv, input logic we, input logic [1:0] wd, input logic sg,
                     input logic [31:0] a, input logic [31:0] wdata,
                     input logic fv, input logic [31:0] fa);
    int   tries;
    logic rdy;
    logic err;
    exp_t e;
    @(negedge clk);
    d_valid = dv; d_we = we; d_width = wd; d_signed = sg; d_addr = a; d_wdata = wdata;
    tries = 0;
    while (dv && !d_ready && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    rdy = d_ready;
    if (dv && !rdy) chk("d_ready_timeout", 64'(rdy), 64'd1);
    i_valid = fv; i_addr = fa;
    @(posedge clk);
    e.t = $time + longint'((LAT - 1) * PER + PER / 2);
    if (fv) begin
      e.err = 1'b0; e.data = mdl[fa[12:2]];
      iq.push_back(e);
    end
    if (dv && rdy) begin
      err = (wd == 2'b11) || (wd == 2'b01 && a[0]) || (wd == 2'b10 && a[1:0] != 2'b00);
      if (!we) begin
        e.err = err; e.data = err ? 32'h0 : mdl_load(mdl[a[12:2]], wd, a[1:0], sg);
        dq.push_back(e);
      end else if (err) begin
        e.err = 1'b1; e.data = 32'h0;
        dq.push_back(e);
      end else begin
        mdl[a[12:2]] = mdl_store(mdl[a[12:2]], wdata, wd, a[1:0]);
      end
    end
    #1;
    d_valid = 1'b0; i_valid = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("rst_d_err",    64'(d_err),    64'd0);
    chk("rst_d_rdata",  64'(d_rdata),  64'd0);
    chk("rst_i_rvalid", 64'(i_rvalid), 64'd0);
    chk("rst_i_rdata",  64'(i_rdata),  64'd0);
    chk("rst_d_ready",  64'(d_ready),  64'd0);
`ifdef PIPE_MEM_STATS_EN
    chk("rst_stat_loads",  64'(stat_loads),  64'd0);
    chk("rst_stat_stores", 64'(stat_stores), 64'd0);
    chk("rst_stat_errs",   64'(stat_errs),   64'd0);
`endif
  endtask

  // Data-port response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (d_rvalid) begin
      if (dq.size() == 0) begin
        chk("d_unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        e = dq.pop_front();
        chk("d_rdata", 64'(d_rdata), 64'(e.data));
        chk("d_err",   64'(d_err),   64'(e.err));
        chk("d_latency_time", 64'($time), 64'(e.t));
      end
    end else if (dq.size() > 0 && dq[0].t <= $time) begin
      e = dq.pop_front();
      chk("d_missing_rvalid", 64'd0, 64'd1);
    end
  end

  // Fetch-port response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (i_rvalid) begin
      if (iq.size() == 0) begin
        chk("i_unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        e = iq.pop_front();
        chk("i_rdata", 64'(i_rdata), 64'(e.data));
        chk("i_latency_time", 64'($time), 64'(e.t));
      end
    end else if (iq.size() > 0 && iq[0].t <= $time) begin
      e = iq.pop_front();
      chk("i_missing_rvalid", 64'd0, 64'd1);
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] old;
    logic [1:0]  wd;
    rst = 1'b1; d_valid = 1'b0; d_we = 1'b0; d_width = 2'b00; d_signed = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; i_valid = 1'b0; i_addr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_d_ready", 64'(d_ready), 64'd1);

    // Initialise words, then word store/load back-to-back.
    req(1, 1, 2'b10, 0, 32'h04, 32'h1122_3344, 0, 0);
    req(1, 1, 2'b10, 0, 32'h20, 32'hAABB_CCDD, 0, 0);
    req(1, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 0);
    req(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0);

    // Byte store and sign/zero-extended loads.
    req(1, 1, 2'b00, 0, 32'h13, 32'h0000_0080, 0, 0);
    req(1, 0, 2'b00, 1, 32'h13, 32'h0, 0, 0);
    req(1, 0, 2'b00, 0, 32'h13, 32'h0, 0, 0);
    req(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0);

    // Half store: one MERGE cycle, same-edge fetch sees the old word.
    req(1, 1, 2'b01, 0, 32'h22, 32'h0000_1234, 1, 32'h20);
    @(negedge clk);
    chk("merge_ready_low", 64'(d_ready), 64'd0);
    @(negedge clk);
    chk("merge_ready_back", 64'(d_ready), 64'd1);
    req(1, 0, 2'b10, 0, 32'h20, 32'h0, 1, 32'h20);
    req(1, 0, 2'b01, 1, 32'h20, 32'h0, 0, 0);

    // Big-endian byte lanes.
    for (int k = 0; k < 4; k++) req(1, 0, 2'b00, 0, 32'h04 + 32'(k), 32'h0, 0, 0);

    // Errors: misaligned word/half, illegal width, rejected store.
    req(1, 0, 2'b10, 0, 32'h05, 32'h0, 0, 0);
    req(1, 1, 2'b10, 0, 32'h06, 32'hFFFF_FFFF, 0, 0);
    req(1, 0, 2'b01, 1, 32'h03, 32'h0, 0, 0);
    req(1, 0, 2'b11, 0, 32'h04, 32'h0, 0, 0);
    req(1, 1, 2'b01, 0, 32'h07, 32'h0000_5555, 0, 0);
    req(1, 0, 2'b10, 0, 32'h04, 32'h0, 0, 0);

    // Address wrap above ABits.
    req(1, 0, 2'b10, 0, 32'h0000_2010, 32'h0, 1, 32'hFFFF_E004);

    // Back-to-back aligned loads with concurrent fetches.
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'h04;
        1:       a = 32'h10;
        default: a = 32'h20;
      endcase
      wd = 2'($urandom_range(0, 2));
      if (wd == 2'b00) a = a + 32'($urandom_range(0, 3));
      else if (wd == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
      req(1, 0, wd, 1'($urandom_range(0, 1)), a, 32'h0, 1'($urandom_range(0, 1)), 32'h10);
    end

    // Reset with a load in flight: its response must be dropped.
    req(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    dq.delete(); iq.delete();
    @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;

    // Reset during MERGE: the pending write and in-flight fetch are dropped.
    old = mdl[32'h20 >> 2];
    req(1, 1, 2'b01, 0, 32'h22, 32'h0000_5A5A, 1, 32'h20);
    mdl[32'h20 >> 2] = old;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    dq.delete(); iq.delete();
    @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    req(1, 0, 2'b10, 0, 32'h20, 32'h0, 0, 0);

    repeat (LAT + 3) @(negedge clk);
    chk("d_queue_drained", 64'(dq.size()), 64'd0);
    chk("i_queue_drained", 64'(iq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
